// File: rtl/imem_responder.sv
// Instruction-memory responder: fixed-latency, in-order fetch responses with credit flow control,
// flush, and a preload write port. Optional statistics counters under `IMEM_STATS_EN.
module imem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2,
  parameter int QDEPTH      = 4
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [63:0] req_addr,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_instr,
  output logic [63:0] rsp_addr,
  output logic        rsp_fault,
  input  logic        flush,
  input  logic        wr_en,
  input  logic [63:0] wr_addr,
  input  logic [31:0] wr_data
`ifdef IMEM_STATS_EN
  ,
  output logic [31:0] stat_fetches,
  output logic [31:0] stat_stalls,
  output logic [31:0] stat_flushed
`endif
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int PW = $clog2(QDEPTH);
  localparam int CW = $clog2(QDEPTH + 1);
  localparam logic [63:0] LIMIT = 64'(DEPTH_WORDS) << 2;
  localparam logic [31:0] NOP   = 32'hD503201F;

  // Handshakes: a transfer happens at a rising edge where valid & ready are both 1; valid and
  // payload stay stable until that edge, and ready never depends combinationally on valid.
  logic          accept;
  logic          pop;
  logic          push;
  logic          req_fault;
  logic          wr_ok;
  logic [AW-1:0] req_idx;
  logic [AW-1:0] wr_idx;

  assign accept    = req_valid & req_ready;
  assign req_fault = (req_addr[1:0] != 2'b00) || (req_addr >= LIMIT);
  assign req_idx   = req_addr[AW+1:2];
  assign wr_ok     = wr_en & ~reset & (wr_addr[1:0] == 2'b00) & (wr_addr < LIMIT);
  assign wr_idx    = wr_addr[AW+1:2];

  // Instruction storage; deliberately not cleared by reset.
  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge CLK) begin
    if (wr_ok) mem[wr_idx] <= wr_data;
  end

  // Latency pipe: stage k holds a request accepted k edges earlier.
  logic [LATENCY-1:0] p_valid;
  logic [LATENCY-1:0] p_fault;
  logic [63:0]        p_addr  [LATENCY];
  logic [31:0]        p_instr [LATENCY];

  always_ff @(posedge CLK) begin
    if (reset) begin
      p_valid <= '0;
    end else begin
      p_valid[0] <= accept;
      for (int k = 1; k < LATENCY; k++) p_valid[k] <= p_valid[k-1] & ~flush;
    end
  end

  always_ff @(posedge CLK) begin
    if (accept) begin
      p_addr[0]  <= req_addr;
      p_fault[0] <= req_fault;
      if (req_fault) p_instr[0] <= NOP;
      else           p_instr[0] <= mem[req_idx];
    end
    for (int k = 1; k < LATENCY; k++) begin
      p_addr[k]  <= p_addr[k-1];
      p_fault[k] <= p_fault[k-1];
      p_instr[k] <= p_instr[k-1];
    end
  end

  // Output queue: credits guarantee it never holds more than QDEPTH entries.
  logic [63:0]       q_addr  [QDEPTH];
  logic [31:0]       q_instr [QDEPTH];
  logic [QDEPTH-1:0] q_fault;
  logic [PW-1:0]     q_rd;
  logic [PW-1:0]     q_wr;
  logic [CW-1:0]     q_cnt;

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(QDEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign push      = p_valid[LATENCY-1] & ~flush;
  assign rsp_valid = (q_cnt != '0);
  assign pop       = rsp_valid & rsp_ready;

  always_ff @(posedge CLK) begin
    if (reset || flush) begin
      q_rd  <= '0;
      q_wr  <= '0;
      q_cnt <= '0;
    end else begin
      if (push) q_wr <= bump(q_wr);
      if (pop)  q_rd <= bump(q_rd);
      q_cnt <= q_cnt + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge CLK) begin
    if (push) begin
      q_addr[q_wr]  <= p_addr[LATENCY-1];
      q_instr[q_wr] <= p_instr[LATENCY-1];
      q_fault[q_wr] <= p_fault[LATENCY-1];
    end
  end

  assign rsp_instr = rsp_valid ? q_instr[q_rd] : '0;
  assign rsp_addr  = rsp_valid ? q_addr[q_rd]  : '0;
  assign rsp_fault = rsp_valid ? q_fault[q_rd] : 1'b0;

  // Credits: outstanding counts pipe plus queue; a flush keeps only the same-cycle redirect fetch.
  logic [CW-1:0] out_cnt;
  logic [CW-1:0] out_cnt_next;

  always_comb begin
    out_cnt_next = out_cnt;
    if (flush) out_cnt_next = CW'(accept);
    else       out_cnt_next = out_cnt + CW'(accept) - CW'(pop);
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      out_cnt   <= '0;
      req_ready <= 1'b0;
    end else begin
      out_cnt   <= out_cnt_next;
      req_ready <= (out_cnt_next < CW'(QDEPTH));
    end
  end

`ifdef IMEM_STATS_EN
  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[32] ? '1 : s[31:0];
  endfunction

  // A response popped in the flush cycle was consumed, so it is not counted as discarded.
  logic [CW-1:0] flush_drop;
  assign flush_drop = out_cnt - CW'(pop);

  always_ff @(posedge CLK) begin
    if (reset) begin
      stat_fetches <= '0;
      stat_stalls  <= '0;
      stat_flushed <= '0;
    end else begin
      if (accept)                  stat_fetches <= sat_add(stat_fetches, 32'd1);
      if (req_valid && !req_ready) stat_stalls  <= sat_add(stat_stalls, 32'd1);
      if (flush)                   stat_flushed <= sat_add(stat_flushed, 32'(flush_drop));
    end
  end
`endif

endmodule

// File: tb/tb_imem_responder.sv
// Bench for imem_responder: directed scenarios plus randomized traffic checked every cycle
// against a queue-based model of accepted-but-unconsumed fetches.
module tb_imem_responder;

  localparam int DEPTH_WORDS = 1024;
  localparam int LATENCY     = 2;
  localparam int QDEPTH      = 4;
  localparam logic [31:0] NOP   = 32'hD503201F;
  localparam logic [63:0] LIMIT = 64'(4 * DEPTH_WORDS);

  logic        CLK = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [63:0] req_addr = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_instr;
  logic [63:0] rsp_addr;
  logic        rsp_fault;
  logic        flush = 1'b0;
  logic        wr_en = 1'b0;
  logic [63:0] wr_addr = '0;
  logic [31:0] wr_data = '0;
`ifdef IMEM_STATS_EN
  logic [31:0] stat_fetches;
  logic [31:0] stat_stalls;
  logic [31:0] stat_flushed;
`endif

  imem_responder #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .LATENCY    (LATENCY),
    .QDEPTH     (QDEPTH)
  ) dut (
    .CLK      (CLK),
    .reset    (reset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_addr (req_addr),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_instr(rsp_instr),
    .rsp_addr (rsp_addr),
    .rsp_fault(rsp_fault),
    .flush    (flush),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data)
`ifdef IMEM_STATS_EN
    ,
    .stat_fetches(stat_fetches),
    .stat_stalls (stat_stalls),
    .stat_flushed(stat_flushed)
`endif
  );

  // ---------------- clock ----------------
  always #5 CLK = ~CLK;

  // ---------------- scoreboard state ----------------
  typedef struct packed {
    logic [63:0] addr;
    logic [31:0] instr;
    logic        fault;
    logic [31:0] acc;
  } rsp_t;

  rsp_t        exp_q[$];
  rsp_t        got_q[$];
  logic [31:0] ref_mem [DEPTH_WORDS];
  int unsigned ec = 0;
  logic        m_ready = 1'b0;
  logic        chk_en = 1'b0;
  logic [31:0] m_fetch = '0;
  logic [31:0] m_stall = '0;
  logic [31:0] m_flushed = '0;
  int          n_cmp = 0;
  int          n_fail = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // The head response is visible once LATENCY edges have passed since its acceptance.
  function automatic bit m_valid();
    return (exp_q.size() > 0) && (exp_q[0].acc + LATENCY <= ec);
  endfunction

  function automatic bit addr_bad(input logic [63:0] a);
    return (a % 4 != 0) || (a >= LIMIT);
  endfunction

  // Model update at each edge, from the inputs the DUT sees at that edge.
  always @(posedge CLK) begin
    rsp_t e;
    logic acc_now;
    logic pop_now;
    if (reset) begin
      exp_q.delete();
      m_ready   = 1'b0;
      m_fetch   = '0;
      m_stall   = '0;
      m_flushed = '0;
      chk_en    = 1'b1;
    end else begin
      acc_now = req_valid && m_ready;
      pop_now = m_valid() && rsp_ready;
      if (req_valid && !m_ready) m_stall = m_stall + 1;
      if (pop_now) void'(exp_q.pop_front());
      if (flush) begin
        m_flushed = m_flushed + 32'(exp_q.size());
        exp_q.delete();
      end
      if (acc_now) begin
        e.addr  = req_addr;
        e.fault = addr_bad(req_addr);
        e.instr = e.fault ? NOP : ref_mem[int'(req_addr >> 2)];
        e.acc   = ec + 1;
        exp_q.push_back(e);
        m_fetch = m_fetch + 1;
      end
      if (wr_en && !addr_bad(wr_addr)) ref_mem[int'(wr_addr >> 2)] = wr_data;
      m_ready = (exp_q.size() < QDEPTH);
    end
    ec++;
  end

  // Compare process, away from the active edge.
  always @(negedge CLK) begin
    rsp_t g;
    if (chk_en) begin
      check("req_ready", 64'(req_ready), 64'(m_ready));
      check("rsp_valid", 64'(rsp_valid), 64'(m_valid()));
      if (rsp_valid && m_valid()) begin
        check("rsp_addr",  rsp_addr,         exp_q[0].addr);
        check("rsp_instr", 64'(rsp_instr),   64'(exp_q[0].instr));
        check("rsp_fault", 64'(rsp_fault),   64'(exp_q[0].fault));
      end
      if (rsp_valid && rsp_ready) begin
        g.addr  = rsp_addr;
        g.instr = rsp_instr;
        g.fault = rsp_fault;
        g.acc   = '0;
        got_q.push_back(g);
      end
`ifdef IMEM_STATS_EN
      check("stat_fetches", 64'(stat_fetches), 64'(m_fetch));
      check("stat_stalls",  64'(stat_stalls),  64'(m_stall));
      check("stat_flushed", 64'(stat_flushed), 64'(m_flushed));
`endif
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic send(input logic [63:0] a);
    bit done;
    done      = 1'b0;
    req_valid = 1'b1;
    req_addr  = a;
    for (int c = 0; c < 20 && !done; c++) begin
      done = req_ready;
      tick();
    end
    req_valid = 1'b0;
    check("send_accepted", 64'(done), 64'd1);
  endtask

  function automatic logic [63:0] rand_addr();
    int unsigned r;
    r = $urandom_range(0, 9);
    if (r < 7)       return 64'(4 * $urandom_range(0, 15));
    else if (r == 7) return 64'(4 * $urandom_range(0, 15) + $urandom_range(1, 3));
    else if (r == 8) return LIMIT + 64'(4 * $urandom_range(0, 3));
    else             return {32'($urandom) | 32'h1, 32'($urandom)};
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    int k;
    bit rdy;
    logic [31:0] snap;
    snap = '0;

    // reset values
    reset = 1'b1;
    tick();
    tick();
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_instr", 64'(rsp_instr), 64'd0);
    check("rst_rsp_addr",  rsp_addr,       64'd0);
    check("rst_rsp_fault", 64'(rsp_fault), 64'd0);
    reset = 1'b0;
    tick();
    check("post_rst_ready", 64'(req_ready), 64'd1);

    // preload words 0..15
    for (int i = 0; i < 16; i++) begin
      wr_en   = 1'b1;
      wr_addr = 64'(4 * i);
      wr_data = (i < 8) ? 32'h11111111 * 32'(i + 1) : $urandom;
      tick();
    end
    wr_en = 1'b0;
    tick();

    // back-to-back fetches, latency and ordering
    rsp_ready = 1'b1;
    got_q.delete();
    for (int i = 0; i < 4; i++) begin
      req_valid = 1'b1;
      req_addr  = 64'(4 * i);
      tick();
      if (i == 1) check("t1_not_early", 64'(rsp_valid), 64'd0);
      if (i == 2) begin
        check("t1_first_valid", 64'(rsp_valid), 64'd1);
        check("t1_first_instr", 64'(rsp_instr), 64'h11111111);
      end
    end
    req_valid = 1'b0;
    check("t1_b2b_valid", 64'(rsp_valid), 64'd1);
    repeat (4) tick();
    check("t1_count", 64'(got_q.size()), 64'd4);
    for (int i = 0; i < 4 && i < got_q.size(); i++) begin
      check("t1_instr", 64'(got_q[i].instr), 64'(32'h11111111 * 32'(i + 1)));
      check("t1_addr",  got_q[i].addr,        64'(4 * i));
    end

    // credit limit with rsp_ready held low
    rsp_ready = 1'b0;
    got_q.delete();
    k = 0;
    for (int c = 0; c < 10; c++) begin
      req_valid = (k < 6);
      req_addr  = 64'(4 * k);
      rdy = req_ready;
      tick();
      if (rdy && req_valid) k++;
    end
    check("t2_accepted", 64'(k), 64'd4);
    check("t2_ready_low", 64'(req_ready), 64'd0);
    check("t2_no_rsp", 64'(got_q.size()), 64'd0);
    rsp_ready = 1'b1;
    for (int c = 0; c < 30 && k < 6; c++) begin
      req_valid = 1'b1;
      req_addr  = 64'(4 * k);
      rdy = req_ready;
      tick();
      if (rdy) k++;
    end
    req_valid = 1'b0;
    check("t2_all_accepted", 64'(k), 64'd6);
    repeat (6) tick();
    check("t2_count", 64'(got_q.size()), 64'd6);
    for (int i = 0; i < 6 && i < got_q.size(); i++) begin
      check("t2_instr", 64'(got_q[i].instr), 64'(32'h11111111 * 32'(i + 1)));
      check("t2_addr",  got_q[i].addr,        64'(4 * i));
    end

    // faults: misaligned and out of range
    got_q.delete();
    send(64'h6);
    send(LIMIT);
    repeat (5) tick();
    check("t3_count", 64'(got_q.size()), 64'd2);
    if (got_q.size() == 2) begin
      check("t3_mis_fault", 64'(got_q[0].fault), 64'd1);
      check("t3_mis_instr", 64'(got_q[0].instr), 64'(NOP));
      check("t3_mis_addr",  got_q[0].addr,        64'h6);
      check("t3_oor_fault", 64'(got_q[1].fault), 64'd1);
      check("t3_oor_instr", 64'(got_q[1].instr), 64'(NOP));
      check("t3_oor_addr",  got_q[1].addr,        64'h1000);
    end

    // flush with a same-cycle redirect fetch
    rsp_ready = 1'b0;
    got_q.delete();
`ifdef IMEM_STATS_EN
    snap = stat_flushed;
`endif
    send(64'h0);
    send(64'h4);
    send(64'hC);
    check("t4_ready_before_flush", 64'(req_ready), 64'd1);
    flush     = 1'b1;
    req_valid = 1'b1;
    req_addr  = 64'h8;
    tick();
    flush     = 1'b0;
    req_valid = 1'b0;
    check("t4_valid_after_flush", 64'(rsp_valid), 64'd0);
`ifdef IMEM_STATS_EN
    check("t4_stat_flushed", 64'(stat_flushed - snap), 64'd3);
`endif
    rsp_ready = 1'b1;
    repeat (5) tick();
    check("t4_count", 64'(got_q.size()), 64'd1);
    if (got_q.size() == 1) begin
      check("t4_instr", 64'(got_q[0].instr), 64'h33333333);
      check("t4_addr",  got_q[0].addr,        64'h8);
    end

    // write and fetch of the same word at the same edge
    got_q.delete();
    wr_en     = 1'b1;
    wr_addr   = 64'h0;
    wr_data   = 32'hAAAAAAAA;
    req_valid = 1'b1;
    req_addr  = 64'h0;
    check("t5_ready", 64'(req_ready), 64'd1);
    tick();
    wr_en     = 1'b0;
    req_valid = 1'b0;
    repeat (3) tick();
    send(64'h0);
    repeat (4) tick();
    check("t5_count", 64'(got_q.size()), 64'd2);
    if (got_q.size() == 2) begin
      check("t5_old", 64'(got_q[0].instr), 64'h11111111);
      check("t5_new", 64'(got_q[1].instr), 64'hAAAAAAAA);
    end

    // reset with outstanding responses
    rsp_ready = 1'b0;
    got_q.delete();
    send(64'h4);
    send(64'h8);
    send(64'hC);
    for (int c = 0; c < 10 && !rsp_valid; c++) tick();
    check("t6_valid_before", 64'(rsp_valid), 64'd1);
    reset = 1'b1;
    tick();
    check("t6_valid_rst", 64'(rsp_valid), 64'd0);
    check("t6_ready_rst", 64'(req_ready), 64'd0);
    check("t6_instr_rst", 64'(rsp_instr), 64'd0);
    check("t6_addr_rst",  rsp_addr,       64'd0);
    reset = 1'b0;
    tick();
    check("t6_ready_after", 64'(req_ready), 64'd1);
    rsp_ready = 1'b1;
    repeat (6) tick();
    check("t6_no_stale", 64'(got_q.size()), 64'd0);

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      req_valid = ($urandom_range(0, 3) != 0);
      req_addr  = rand_addr();
      rsp_ready = ($urandom_range(0, 3) != 0);
      wr_en     = ($urandom_range(0, 15) == 0);
      wr_addr   = rand_addr();
      wr_data   = $urandom;
      flush     = ($urandom_range(0, 29) == 0);
      reset     = ($urandom_range(0, 299) == 0);
      tick();
    end
    req_valid = 1'b0;
    wr_en     = 1'b0;
    flush     = 1'b0;
    reset     = 1'b0;
    rsp_ready = 1'b1;
    repeat (12) tick();
    check("end_drained", 64'(exp_q.size()), 64'd0);

    // ---------------- report ----------------
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
